kalman_stream_bridge: RTL and testbench
=======================================

Name: kalman_stream_bridge

Overview:
- Streaming front/back end for the Kalman filter core.
- Deserialises a 32-bit valid/ready input frame (x, P, z) into the core's flat input vectors and pulses the core's start.
- Waits for the core's done pulse, then serialises the core's x_out and P_out back out as a 32-bit valid/ready frame with a last flag.
- Sits between the AXI-Stream DMA path and the filter core, so that only state, covariance and measurement words cross the bus.

Parameters:
- N_STATE, 6, state vector length; P is N_STATE×N_STATE.
- N_MEAS, 4, measurement vector length.
- W, 32, word width (Q20.12 fixed point, passed through untouched).
- Derived, not overridable: IN_WORDS = N_STATE + N_STATE² + N_MEAS = 46; OUT_WORDS = N_STATE + N_STATE² = 42.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- s_tdata  in  W  input stream data
- s_tvalid  in  1  input word valid
- s_tready  out  1  bridge accepts input word
- s_tlast  in  1  marks final word of input frame
- m_tdata  out  W  output stream data
- m_tvalid  out  1  output word valid
- m_tready  in  1  downstream accepts output word
- m_tlast  out  1  marks final word of output frame
- kf_start  out  1  one-cycle start pulse to filter core
- kf_done  in  1  one-cycle done pulse from filter core
- kf_x_flat  out  N_STATE*W  state vector to core
- kf_P_flat  out  N_STATE²*W  covariance to core
- kf_z_flat  out  N_MEAS*W  measurement to core
- kf_x_out  in  N_STATE*W  updated state from core
- kf_P_out  in  N_STATE²*W  updated covariance from core
- busy  out  1  high in any state other than LOAD
- frame_err  out  1  one-cycle pulse on a malformed input frame

Behaviour:
- Interface: reset rst, asynchronous, active-high; clock clk.
- Reset values: state = LOAD, word counters 0, all flat registers 0, s_tready = 1, m_tvalid = 0, m_tlast = 0, m_tdata = 0, kf_start = 0, busy = 0, frame_err = 0.
- Reset mid-operation (any state, including while the core is running or output is draining) returns to LOAD immediately. Any partial output frame is abandoned; the core is not signalled.
- Input word ordering: input words are x[0..5], then P row-major [0..35], then z[0..3]. Word k of each vector is written MSB-first into bits [TOTAL-1-W*k -: W], so element 0 occupies the top 32 bits.
- Output word ordering: x_out, then P_out, using the same MSB-first ordering.
- A beat transfers when valid && ready on a rising edge.

State machine:
- LOAD:
  - s_tready = 1. Each accepted beat is written into its slot and in_cnt is incremented.
  - Beat with in_cnt = IN_WORDS-1 and s_tlast = 1: go to FIRE.
  - Beat with s_tlast = 1 and in_cnt < IN_WORDS-1 (short frame): pulse frame_err, set in_cnt = 0, stay in LOAD. Registers already written are not cleared.
  - Beat with in_cnt = IN_WORDS-1 and s_tlast = 0 (long frame): pulse frame_err, go to SKIP.
- SKIP: s_tready = 1. Beats are discarded. On a beat with s_tlast = 1, set in_cnt = 0 and go to LOAD.
- FIRE: s_tready = 0, kf_start = 1 for exactly this one cycle, then go to WAIT.
- WAIT:
  - s_tready = 0. kf_x_flat, kf_P_flat and kf_z_flat are held stable.
  - On the cycle kf_done = 1, kf_x_out and kf_P_out are captured into the output buffer, out_cnt = 0, go to DRAIN.
  - kf_done seen in any state other than WAIT is ignored.
- DRAIN:
  - m_tvalid = 1; m_tdata = buffer word out_cnt; m_tlast = 1 when out_cnt = OUT_WORDS-1.
  - m_tdata and m_tlast stay stable while m_tvalid && !m_tready.
  - Each handshake increments out_cnt.
  - Handshake on the last word: m_tvalid goes to 0 the next cycle, in_cnt = 0, go to LOAD.
- Latency:
  - Last input beat at edge T: kf_start is high in cycle T+1.
  - kf_done sampled at edge D: first output word is valid in cycle D+1.
  - With m_tready held high, the output frame takes exactly OUT_WORDS cycles.
- Input and output are never concurrent; s_tready is 0 in FIRE, WAIT and DRAIN.
- Counters are log2-sized to IN_WORDS and OUT_WORDS; they never wrap, because the state changes first.
- No arithmetic is performed; data is passed bit-exact.

Test Plan:
- Normal frame: 46 beats with values 1..46 and tlast on beat 46 → kf_x_flat[191:160] = 1, kf_P_flat[1151:1120] = 7, kf_z_flat[31:0] = 46; kf_start is one pulse the cycle after beat 46; s_tready = 0 afterwards.
- Core completion: set kf_x_out word0 = 32'h1000 and kf_P_out word35 = 32'hDEAD, pulse kf_done → next cycle m_tdata = 32'h1000, m_tvalid = 1; the 42nd word = 32'hDEAD with m_tlast = 1; then back to LOAD with s_tready = 1.
- Back-pressure: toggle m_tready randomly during DRAIN → m_tdata and m_tlast are stable while stalled, no word is lost or duplicated, and exactly 42 handshakes occur.
- Short frame: tlast on beat 10 → frame_err pulses once, no kf_start; a following valid 46-beat frame loads correctly.
- Long frame: 50 beats with tlast on beat 50 → frame_err pulses at beat 46, beats 47–50 are discarded, no kf_start; the next good frame works.
- Reset mid-DRAIN after 5 words → m_tvalid = 0 and s_tready = 1 immediately; a fresh frame completes normally.

Source files
------------

// File: rtl/kalman_stream_bridge_if.sv
// One direction of a 32-bit valid/ready word stream with an end-of-frame flag.
// The master drives data/valid/last, the slave answers with ready.
interface kalman_stream_bridge_if #(
    parameter int W = 32
) ();
    logic [W-1:0] tdata;
    logic         tvalid;
    logic         tready;
    logic         tlast;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/kalman_stream_bridge.sv
// Frames x/P/z words into the filter core's flat inputs, fires it, then streams x_out/P_out back out.
// kf_start one cycle after the last input beat, first output word one cycle after kf_done; input and output never overlap.
module kalman_stream_bridge #(
    parameter int N_STATE = 6,
    parameter int N_MEAS  = 4,
    parameter int W       = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    kalman_stream_bridge_if.slave         s_axis,
    kalman_stream_bridge_if.master        m_axis,
    output logic                          kf_start,
    input  logic                          kf_done,
    output logic [N_STATE*W-1:0]          kf_x_flat,
    output logic [N_STATE*N_STATE*W-1:0]  kf_P_flat,
    output logic [N_MEAS*W-1:0]           kf_z_flat,
    input  logic [N_STATE*W-1:0]          kf_x_out,
    input  logic [N_STATE*N_STATE*W-1:0]  kf_P_out,
    output logic                          busy,
    output logic                          frame_err
);
    localparam int N_P       = N_STATE * N_STATE;
    localparam int IN_WORDS  = N_STATE + N_P + N_MEAS;
    localparam int OUT_WORDS = N_STATE + N_P;
    localparam int IC_W      = $clog2(IN_WORDS);
    localparam int OC_W      = $clog2(OUT_WORDS);
    localparam int X_BITS    = N_STATE * W;
    localparam int P_BITS    = N_P * W;
    localparam int Z_BITS    = N_MEAS * W;
    localparam int O_BITS    = OUT_WORDS * W;

    typedef enum logic [2:0] {
        S_LOAD,
        S_SKIP,
        S_FIRE,
        S_WAIT,
        S_DRAIN
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [IC_W-1:0]   r_in_cnt;
    logic [OC_W-1:0]   r_out_cnt;
    logic [X_BITS-1:0] r_x;
    logic [P_BITS-1:0] r_P;
    logic [Z_BITS-1:0] r_z;
    logic [O_BITS-1:0] r_out;
    logic              r_err;

    logic              w_s_rdy;
    logic              w_m_vld;
    logic              w_start;
    logic              w_in_last_slot;
    logic              w_out_last;
    logic [W-1:0]      w_out_word;

    assign w_in_last_slot = (r_in_cnt == IC_W'(IN_WORDS - 1));
    assign w_out_last     = (r_out_cnt == OC_W'(OUT_WORDS - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_LOAD;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_s_rdy     = 1'b0;
        w_m_vld     = 1'b0;
        w_start     = 1'b0;
        case (r_state)
            S_LOAD: begin
                w_s_rdy = 1'b1;
                if (s_axis.tvalid && w_in_last_slot) begin
                    w_state_nxt = s_axis.tlast ? S_FIRE : S_SKIP;
                end
            end
            S_SKIP: begin
                w_s_rdy = 1'b1;
                if (s_axis.tvalid && s_axis.tlast) begin
                    w_state_nxt = S_LOAD;
                end
            end
            S_FIRE: begin
                w_start     = 1'b1;
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (kf_done) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                w_m_vld = 1'b1;
                if (m_axis.tready && w_out_last) begin
                    w_state_nxt = S_LOAD;
                end
            end
            default: w_state_nxt = S_LOAD;
        endcase
    end

    // The input counter parks on the last slot through FIRE/WAIT/DRAIN and is cleared on the way back to LOAD.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_in_cnt  <= '0;
            r_out_cnt <= '0;
            r_x       <= '0;
            r_P       <= '0;
            r_z       <= '0;
            r_out     <= '0;
            r_err     <= 1'b0;
        end else begin
            r_err <= 1'b0;
            case (r_state)
                S_LOAD: begin
                    if (s_axis.tvalid) begin
                        for (int k = 0; k < N_STATE; k++) begin
                            if (r_in_cnt == IC_W'(k)) r_x[X_BITS-1-W*k -: W] <= s_axis.tdata;
                        end
                        for (int k = 0; k < N_P; k++) begin
                            if (r_in_cnt == IC_W'(N_STATE + k)) r_P[P_BITS-1-W*k -: W] <= s_axis.tdata;
                        end
                        for (int k = 0; k < N_MEAS; k++) begin
                            if (r_in_cnt == IC_W'(N_STATE + N_P + k)) r_z[Z_BITS-1-W*k -: W] <= s_axis.tdata;
                        end
                        if (w_in_last_slot) begin
                            r_err <= !s_axis.tlast;
                        end else if (s_axis.tlast) begin
                            r_err    <= 1'b1;
                            r_in_cnt <= '0;
                        end else begin
                            r_in_cnt <= r_in_cnt + 1'b1;
                        end
                    end
                end
                S_SKIP: begin
                    if (s_axis.tvalid && s_axis.tlast) begin
                        r_in_cnt <= '0;
                    end
                end
                S_WAIT: begin
                    if (kf_done) begin
                        r_out     <= {kf_x_out, kf_P_out};
                        r_out_cnt <= '0;
                    end
                end
                S_DRAIN: begin
                    if (m_axis.tready) begin
                        if (w_out_last) begin
                            r_out_cnt <= '0;
                            r_in_cnt  <= '0;
                        end else begin
                            r_out_cnt <= r_out_cnt + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_out_word = '0;
        for (int k = 0; k < OUT_WORDS; k++) begin
            if (r_out_cnt == OC_W'(k)) w_out_word = r_out[O_BITS-1-W*k -: W];
        end
    end

    assign s_axis.tready = w_s_rdy;
    assign m_axis.tvalid = w_m_vld;
    assign m_axis.tdata  = w_m_vld ? w_out_word : '0;
    assign m_axis.tlast  = w_m_vld && w_out_last;

    assign kf_start  = w_start;
    assign kf_x_flat = r_x;
    assign kf_P_flat = r_P;
    assign kf_z_flat = r_z;
    assign busy      = (r_state != S_LOAD);
    assign frame_err = r_err;
endmodule

// File: tb/tb_kalman_stream_bridge.sv
// Randomised frames and core responses against a word-level model of the bridge.
module tb_kalman_stream_bridge;
    localparam int W         = 32;
    localparam int NS        = 6;
    localparam int NM        = 4;
    localparam int NP        = NS * NS;
    localparam int IN_WORDS  = NS + NP + NM;
    localparam int OUT_WORDS = NS + NP;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    kalman_stream_bridge_if #(.W(W)) s_if ();
    kalman_stream_bridge_if #(.W(W)) m_if ();

    logic              kf_start;
    logic              kf_done;
    logic [NS*W-1:0]   kf_x_flat;
    logic [NP*W-1:0]   kf_P_flat;
    logic [NM*W-1:0]   kf_z_flat;
    logic [NS*W-1:0]   kf_x_out;
    logic [NP*W-1:0]   kf_P_out;
    logic              busy;
    logic              frame_err;

    kalman_stream_bridge #(.N_STATE(NS), .N_MEAS(NM), .W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .s_axis    (s_if),
        .m_axis    (m_if),
        .kf_start  (kf_start),
        .kf_done   (kf_done),
        .kf_x_flat (kf_x_flat),
        .kf_P_flat (kf_P_flat),
        .kf_z_flat (kf_z_flat),
        .kf_x_out  (kf_x_out),
        .kf_P_out  (kf_P_out),
        .busy      (busy),
        .frame_err (frame_err)
    );

    int checks = 0;
    int errors = 0;

    logic [W-1:0] x_m [NS];
    logic [W-1:0] p_m [NP];
    logic [W-1:0] z_m [NM];
    int           in_pos;
    bit           skipping;
    logic [W-1:0] exp_q [$];
    logic [W-1:0] rec [$];
    bit           last_rec [$];
    int           start_cnt = 0;
    int           err_cnt = 0;
    int           hs_cnt = 0;
    int           vld_cycles = 0;
    bit           prev_stall = 0;
    bit           rdy_rand = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_flats(input string tag);
        int bad;
        logic [W-1:0] g, e, bg, be;
        bad = -1;
        bg = '0;
        be = '0;
        for (int k = 0; k < IN_WORDS; k++) begin
            if (k < NS) begin
                g = kf_x_flat[NS*W-1-W*k -: W];
                e = x_m[k];
            end else if (k < NS + NP) begin
                g = kf_P_flat[NP*W-1-W*(k-NS) -: W];
                e = p_m[k-NS];
            end else begin
                g = kf_z_flat[NM*W-1-W*(k-NS-NP) -: W];
                e = z_m[k-NS-NP];
            end
            if (bad < 0 && g !== e) begin
                bad = k;
                bg = g;
                be = e;
            end
        end
        checks++;
        if (bad >= 0) begin
            errors++;
            $display("FAIL flats_%s word %0d: got %h expected %h", tag, bad, bg, be);
        end
    endtask

    task automatic model_reset();
        foreach (x_m[i]) x_m[i] = '0;
        foreach (p_m[i]) p_m[i] = '0;
        foreach (z_m[i]) z_m[i] = '0;
        in_pos = 0;
        skipping = 0;
        exp_q.delete();
    endtask

    // Frame-level rules: slot write, short/long frame detection, skip until tlast.
    task automatic model_beat(input logic [W-1:0] d, input bit last, output bit err, output bit fire);
        err = 0;
        fire = 0;
        if (skipping) begin
            if (last) begin
                skipping = 0;
                in_pos = 0;
            end
        end else begin
            if (in_pos < NS) x_m[in_pos] = d;
            else if (in_pos < NS + NP) p_m[in_pos-NS] = d;
            else z_m[in_pos-NS-NP] = d;
            if (in_pos == IN_WORDS - 1) begin
                if (last) fire = 1;
                else begin
                    err = 1;
                    skipping = 1;
                end
                in_pos = 0;
            end else if (last) begin
                err = 1;
                in_pos = 0;
            end else begin
                in_pos++;
            end
        end
    endtask

    always @(posedge clk) begin
        #1;
        m_if.tready = rdy_rand ? ($urandom_range(0, 1) == 1) : 1'b1;
    end

    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 0;
        end else begin
            if (kf_start) start_cnt++;
            if (frame_err) err_cnt++;
            chk("io_exclusive", s_if.tready & m_if.tvalid, 0);
            if (prev_stall) chk("stall_keeps_vld", m_if.tvalid, 1);
            if (m_if.tvalid) begin
                vld_cycles++;
                chk("busy_in_drain", busy, 1);
                if (exp_q.size() == 0) begin
                    chk("out_unexpected", m_if.tvalid, 0);
                end else begin
                    chk("out_data", m_if.tdata, exp_q[0]);
                    chk("out_last", m_if.tlast, exp_q.size() == 1);
                    if (m_if.tready) begin
                        rec.push_back(m_if.tdata);
                        last_rec.push_back(m_if.tlast);
                        void'(exp_q.pop_front());
                        hs_cnt++;
                    end
                end
            end else begin
                chk("out_last_idle", m_if.tlast, 0);
            end
            prev_stall = m_if.tvalid && !m_if.tready;
        end
    end

    task automatic send_frame(input int n, input bit seq);
        int b, budget;
        bit xfer, err, fire;
        logic [W-1:0] d;
        b = 0;
        budget = 0;
        while (b < n && budget < 4 * n + 50) begin
            d = seq ? W'(b + 1) : $urandom;
            s_if.tdata  = d;
            s_if.tlast  = (b == n - 1);
            s_if.tvalid = seq || ($urandom_range(0, 3) != 0);
            @(negedge clk);
            xfer = s_if.tvalid && s_if.tready;
            @(posedge clk);
            #1;
            budget++;
            if (xfer) begin
                model_beat(d, b == n - 1, err, fire);
                chk("frame_err", frame_err, err);
                if (b == n - 1) begin
                    chk("start_pulse", kf_start, fire);
                    if (fire) begin
                        chk("fire_s_tready", s_if.tready, 0);
                        chk_flats("fire");
                    end
                end
                b++;
            end
        end
        s_if.tvalid = 0;
        s_if.tlast  = 0;
        chk("frame_sent", b, n);
    endtask

    task automatic run_core(input bit pinned, input bit rand_rdy, input int abort_after);
        int hs0, v0, budget;
        @(posedge clk);
        #1;
        chk("start_one_cycle", kf_start, 0);
        chk("wait_s_tready", s_if.tready, 0);
        chk("wait_busy", busy, 1);
        repeat ($urandom_range(1, 5)) @(posedge clk);
        #1;
        for (int k = 0; k < NS; k++) kf_x_out[NS*W-1-W*k -: W] = $urandom;
        for (int k = 0; k < NP; k++) kf_P_out[NP*W-1-W*k -: W] = $urandom;
        if (pinned) begin
            kf_x_out[NS*W-1 -: W] = 32'h1000;
            kf_P_out[W-1:0]       = 32'hDEAD;
        end
        chk_flats("wait_hold");
        rec.delete();
        last_rec.delete();
        for (int k = 0; k < NS; k++) exp_q.push_back(kf_x_out[NS*W-1-W*k -: W]);
        for (int k = 0; k < NP; k++) exp_q.push_back(kf_P_out[NP*W-1-W*k -: W]);
        rdy_rand = rand_rdy;
        hs0 = hs_cnt;
        v0 = vld_cycles;
        kf_done = 1;
        @(posedge clk);
        #1;
        kf_done = 0;
        chk("first_out_vld", m_if.tvalid, 1);
        if (pinned) chk("first_out_literal", m_if.tdata, 32'h1000);
        budget = 0;
        if (abort_after > 0) begin
            while (hs_cnt - hs0 < abort_after && budget < 500) begin
                @(posedge clk);
                budget++;
            end
            #1;
            rst = 1;
            #1;
            chk("abort_m_tvalid", m_if.tvalid, 0);
            chk("abort_s_tready", s_if.tready, 1);
            chk("abort_busy", busy, 0);
            chk("abort_partial", (hs_cnt - hs0 >= abort_after) && (hs_cnt - hs0 < OUT_WORDS), 1);
            model_reset();
            rdy_rand = 0;
            chk_flats("abort_clear");
            @(posedge clk);
            #1;
            rst = 0;
        end else begin
            while (exp_q.size() != 0 && budget < 2000) begin
                @(posedge clk);
                budget++;
            end
            #1;
            chk("drain_empty", exp_q.size(), 0);
            chk("drain_hs", hs_cnt - hs0, OUT_WORDS);
            chk("end_m_tvalid", m_if.tvalid, 0);
            chk("end_s_tready", s_if.tready, 1);
            chk("end_busy", busy, 0);
            if (!rand_rdy) chk("drain_cycles", vld_cycles - v0, OUT_WORDS);
            if (pinned) begin
                chk("rec_size", rec.size(), OUT_WORDS);
                if (rec.size() == OUT_WORDS) begin
                    chk("last_word_literal", rec[OUT_WORDS-1], 32'hDEAD);
                    chk("last_flag_literal", last_rec[OUT_WORDS-1], 1);
                    chk("prev_flag_literal", last_rec[OUT_WORDS-2], 0);
                end
            end
            rdy_rand = 0;
        end
    endtask

    task automatic bad_frame(input int n, input string tag);
        int s0, e0;
        s0 = start_cnt;
        e0 = err_cnt;
        send_frame(n, 0);
        repeat (2) @(posedge clk);
        #1;
        chk({tag, "_err_pulses"}, err_cnt - e0, 1);
        chk({tag, "_no_start"}, start_cnt - s0, 0);
        chk({tag, "_s_tready"}, s_if.tready, 1);
        chk({tag, "_busy"}, busy, 0);
    endtask

    initial begin
        int s0, e0;
        s_if.tvalid = 0;
        s_if.tdata  = '0;
        s_if.tlast  = 0;
        kf_done     = 0;
        kf_x_out    = '0;
        kf_P_out    = '0;
        model_reset();
        #3;
        chk("rst_s_tready", s_if.tready, 1);
        chk("rst_m_tvalid", m_if.tvalid, 0);
        chk("rst_m_tlast", m_if.tlast, 0);
        chk("rst_m_tdata", m_if.tdata, 0);
        chk("rst_kf_start", kf_start, 0);
        chk("rst_busy", busy, 0);
        chk("rst_frame_err", frame_err, 0);
        chk_flats("reset");
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 0;

        kf_done = 1;
        kf_x_out[NS*W-1 -: W] = $urandom;
        @(posedge clk);
        #1;
        kf_done = 0;
        chk("done_ignored_vld", m_if.tvalid, 0);
        chk("done_ignored_busy", busy, 0);

        s0 = start_cnt;
        e0 = err_cnt;
        send_frame(IN_WORDS, 1);
        chk("x0_literal", kf_x_flat[191:160], 1);
        chk("p0_literal", kf_P_flat[1151:1120], 7);
        chk("z3_literal", kf_z_flat[31:0], 46);
        run_core(1, 0, 0);
        chk("normal_start_cnt", start_cnt - s0, 1);
        chk("normal_err_cnt", err_cnt - e0, 0);

        send_frame(IN_WORDS, 0);
        run_core(0, 1, 0);

        bad_frame(10, "short");
        send_frame(IN_WORDS, 0);
        run_core(0, 1, 0);

        bad_frame(50, "long");
        send_frame(IN_WORDS, 0);
        run_core(0, 1, 0);

        send_frame(IN_WORDS, 0);
        run_core(0, 1, 5);
        send_frame(IN_WORDS, 0);
        run_core(1, 1, 0);

        for (int i = 0; i < 3; i++) begin
            send_frame(IN_WORDS, 0);
            run_core(0, i != 1, 0);
        end

        repeat (3) @(posedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog expired");
    end
endmodule
